decode_basic: RTL and testbench
===============================

// Module: decode_basic
// PURPOSE
//  In-order decode/issue stage: accepts one TinyRV1 instruction per cycle from
//  fetch (F__DIntf), reads the 32x32 architectural register file, tracks RAW
//  hazards with a per-register pending bit, and dispatches a micro-op to the
//  lowest-index ready execute pipe that supports it (D__XIntf array). Register
//  writes arrive on a completion broadcast (CompleteNotif).
// PARAMETERS
//  p_isa_subset    p_tinyrv1            rv_op_vec of ops decode accepts
//  p_num_pipes     1                    number of execute pipes / Ex ports
//  p_pipe_subsets  '{default:p_tinyrv1} per-pipe rv_op_vec of supported ops
//  Widths (addr 32, data 32, seq_num_bits) come from the connected interfaces.
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset (synchronous, active-high)
//  F         F__DIntf    sink: inst[31:0], pc[31:0], val in; rdy out
//  Ex[N-1:0] D__XIntf    source: pc, op1, op2, waddr[4:0], uop (rv_uop), seq_num, val out; rdy in
//  complete  CompleteNotif  in: val, seq_num, waddr[4:0], wdata[31:0], wen (no rdy)
//  trace     (sim-only string function): "pc:uop" on issue, blanks otherwise
// BEHAVIOUR
//  Reset: regfile all 0, all pending bits 0, seq counter 0; all Ex.val=0, F.rdy=0.
//  Decode is combinational, zero latency: F.val&F.rdy fire = Ex[k].val&Ex[k].rdy same cycle.
//  Uop map (imm sign-extended to 32b):
//   add   ADD  op1=R[rs1] op2=R[rs2] waddr=rd   | addi ADD op1=R[rs1] op2=immI waddr=rd
//   mul   MUL  op1=R[rs1] op2=R[rs2] waddr=rd   | lw   LW  op1=R[rs1] op2=immI waddr=rd
//   sw    SW   op1=R[rs1]+immS op2=R[rs2] waddr=0
//   jal   JAL  op1=pc op2=immJ waddr=rd         | jalr JALR op1=R[rs1] op2=immI waddr=rd
//   bne   BNE  op1=R[rs1] op2=R[rs2] waddr=0, Ex.pc = pc+immB (target); all others Ex.pc=pc
//  Register read: x0 always 0; if complete.val&wen&waddr==rs (rs!=0) this cycle, bypass wdata.
//  Stall (F.rdy=0, no Ex.val): any used source rs!=0 pending and not cleared by same-cycle
//   completion; or no pipe k with p_pipe_subsets[k]&vec(uop)!=0 and Ex[k].rdy.
//  Pipe select: lowest k with subset match and Ex[k].rdy; only that Ex[k].val=1.
//  WAW not stalled: issue to an already-pending rd proceeds.
//  On issue with waddr!=0: pending[waddr] set. On complete.val&wen&waddr!=0: R[waddr]<=wdata,
//   pending[waddr] cleared; same-cycle issue setting same reg wins (stays pending).
//  complete.seq_num is ignored (may be X); completions with wen=0 or waddr=0 do nothing.
//  seq_num: Ex.seq_num = counter; counter increments per issue, wraps at 2^seq_num_bits.
//  Illegal/unsupported op (not in p_isa_subset or no pipe ever supports it): consumed
//   (F.rdy=1), not issued, sim $error.
//  Mid-operation reset: in-flight decode discarded, all state returns to reset values.
// STRUCTURE
//  Shared package UArch: rv_uop enum, rv_op_vec, OP_*_VEC one-hots, p_tinyrv1.
//  Interfaces F__DIntf, D__XIntf, CompleteNotif defined in shared intf files.
//  One sub-module natural: decode_regfile (32x32, 2 read + 1 write, x0=0, write bypass).
//  Pending scoreboard, immediate gen, pipe arbiter, seq counter live in top.
// TESTING
//  Basic: send mul x1,x0,x0 @0; addi x1,x0,10 @4 -> (pc0,0,0,x1,MUL),(pc4,0,10,x1,ADD).
//  RAW: pub x1=3,x2=7; add x4,x1,x2; add x2,x5,x4 -> (3,7,x4,ADD); 2nd stalls until
//   pub x4=10, then (0,10,x2,ADD).
//  Imm: pub x1=9; addi x3,x1,10 -> (9,10,x3); pub x3=13; addi x2,x3,2047 -> (13,2047,x2).
//  Routing: subsets {ADD-only, tinyrv1}: mul goes to tinyrv1 pipe, add to lowest ready
//   ADD pipe; 5 pipes with MUL-only pipe 0, 1 pipe, etc.
//  Backpressure: F send delay 3 and/or Ex recv delay 3 -> same message sequence,
//   no drops/duplicates, seq_num increments by 1 per issue and wraps (rob 8).
//  Reset mid-stream: pending/regfile cleared, seq_num restarts at 0.

Source files
------------

// File: rtl/decode_basic_pkg.sv
// Shared decode types: micro-op encoding, op-support vectors and TinyRV1 opcodes.
package decode_basic_pkg;

    typedef enum logic [2:0] {
        UOP_ADD  = 3'd0,
        UOP_MUL  = 3'd1,
        UOP_LW   = 3'd2,
        UOP_SW   = 3'd3,
        UOP_JAL  = 3'd4,
        UOP_JALR = 3'd5,
        UOP_BNE  = 3'd6
    } rv_uop_e;

    localparam int NUM_UOPS = 7;

    // One bit per micro-op; a pipe or ISA subset is the OR of the ops it handles.
    typedef logic [NUM_UOPS-1:0] rv_op_vec_t;

    localparam rv_op_vec_t OP_ADD_VEC  = 7'b000_0001;
    localparam rv_op_vec_t OP_MUL_VEC  = 7'b000_0010;
    localparam rv_op_vec_t OP_LW_VEC   = 7'b000_0100;
    localparam rv_op_vec_t OP_SW_VEC   = 7'b000_1000;
    localparam rv_op_vec_t OP_JAL_VEC  = 7'b001_0000;
    localparam rv_op_vec_t OP_JALR_VEC = 7'b010_0000;
    localparam rv_op_vec_t OP_BNE_VEC  = 7'b100_0000;
    localparam rv_op_vec_t P_TINYRV1   = 7'b111_1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic rv_op_vec_t uop_vec(input rv_uop_e u);
        rv_op_vec_t v;
        v = '0;
        v[u] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 architectural register file: two combinational reads, one write,
// x0 hardwired to zero, same-cycle write data bypassed to the readers.
module decode_regfile
    import decode_basic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr0_i,
    output logic [31:0] rdata0_o,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic        wen_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0][31:0] mem_q;

    // Register storage; x0 is never written.
    always_ff @(posedge clk) begin
        if (rst)                           mem_q <= '0;
        else if (wen_i && waddr_i != 5'd0) mem_q[waddr_i] <= wdata_i;
    end

    // Read ports with x0 forcing and write-through bypass.
    always_comb begin
        rdata0_o = mem_q[raddr0_i];
        rdata1_o = mem_q[raddr1_i];
        if (wen_i && waddr_i == raddr0_i) rdata0_o = wdata_i;
        if (wen_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
        if (raddr0_i == 5'd0)             rdata0_o = '0;
        if (raddr1_i == 5'd0)             rdata1_o = '0;
    end

endmodule

// File: rtl/decode_basic.sv
// In-order decode/issue: decodes one TinyRV1 instruction per cycle, stalls on
// RAW hazards via a pending-write scoreboard, and dispatches the micro-op to the
// lowest-index ready execute pipe that supports it.
module decode_basic
    import decode_basic_pkg::*;
#(
    parameter rv_op_vec_t                   P_ISA_SUBSET   = P_TINYRV1,
    parameter int                           P_NUM_PIPES    = 1,
    parameter rv_op_vec_t [P_NUM_PIPES-1:0] P_PIPE_SUBSETS = {P_NUM_PIPES{P_TINYRV1}},
    parameter int                           P_SEQ_BITS     = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [31:0]                             f_inst_i,
    input  logic [31:0]                             f_pc_i,
    input  logic                                    f_val_i,
    output logic                                    f_rdy_o,
    output logic [P_NUM_PIPES-1:0][31:0]            ex_pc_o,
    output logic [P_NUM_PIPES-1:0][31:0]            ex_op1_o,
    output logic [P_NUM_PIPES-1:0][31:0]            ex_op2_o,
    output logic [P_NUM_PIPES-1:0][4:0]             ex_waddr_o,
    output rv_uop_e [P_NUM_PIPES-1:0]               ex_uop_o,
    output logic [P_NUM_PIPES-1:0][P_SEQ_BITS-1:0]  ex_seq_num_o,
    output logic [P_NUM_PIPES-1:0]                  ex_val_o,
    input  logic [P_NUM_PIPES-1:0]                  ex_rdy_i,
    input  logic                                    cmp_val_i,
    input  logic [P_SEQ_BITS-1:0]                   cmp_seq_num_i,
    input  logic [4:0]                              cmp_waddr_i,
    input  logic [31:0]                             cmp_wdata_i,
    input  logic                                    cmp_wen_i
);

    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, rdata1, rdata2;
    logic [31:0] op1, op2, pc_out;
    logic [4:0]  waddr;
    rv_uop_e     uop;
    logic        known, use1, use2, legal, haz, found, issue, cmp_wr;
    rv_op_vec_t  vec, any_sup;
    logic [P_NUM_PIPES-1:0] sel;
    logic [31:0] pend_q, pend_d;
    logic [P_SEQ_BITS-1:0] seq_q, seq_d;

    // The completion tag carries no information this stage needs.
    logic unused_cmp_seq;
    assign unused_cmp_seq = ^cmp_seq_num_i;

    assign rd     = f_inst_i[11:7];
    assign rs1    = f_inst_i[19:15];
    assign rs2    = f_inst_i[24:20];
    assign imm_i  = {{20{f_inst_i[31]}}, f_inst_i[31:20]};
    assign imm_s  = {{20{f_inst_i[31]}}, f_inst_i[31:25], f_inst_i[11:7]};
    assign imm_b  = {{19{f_inst_i[31]}}, f_inst_i[31], f_inst_i[7], f_inst_i[30:25], f_inst_i[11:8], 1'b0};
    assign imm_j  = {{11{f_inst_i[31]}}, f_inst_i[31], f_inst_i[19:12], f_inst_i[20], f_inst_i[30:21], 1'b0};
    assign cmp_wr = cmp_val_i && cmp_wen_i;

    decode_regfile u_rf (
        .clk      (clk),
        .rst      (rst),
        .raddr0_i (rs1),
        .rdata0_o (rdata1),
        .raddr1_i (rs2),
        .rdata1_o (rdata2),
        .wen_i    (cmp_wr),
        .waddr_i  (cmp_waddr_i),
        .wdata_i  (cmp_wdata_i)
    );

    // Instruction decode into micro-op, operands and destination.
    always_comb begin
        known  = 1'b0;
        uop    = UOP_ADD;
        use1   = 1'b0;
        use2   = 1'b0;
        op1    = rdata1;
        op2    = rdata2;
        waddr  = rd;
        pc_out = f_pc_i;
        case (f_inst_i[6:0])
            OPC_OP: if (f_inst_i[14:12] == 3'b000 && f_inst_i[31:25] == 7'b0000000) begin
                known = 1'b1; use1 = 1'b1; use2 = 1'b1;
            end else if (f_inst_i[14:12] == 3'b000 && f_inst_i[31:25] == 7'b0000001) begin
                known = 1'b1; use1 = 1'b1; use2 = 1'b1; uop = UOP_MUL;
            end
            OPC_IMM: if (f_inst_i[14:12] == 3'b000) begin
                known = 1'b1; use1 = 1'b1; op2 = imm_i;
            end
            OPC_LOAD: if (f_inst_i[14:12] == 3'b010) begin
                known = 1'b1; use1 = 1'b1; op2 = imm_i; uop = UOP_LW;
            end
            OPC_STORE: if (f_inst_i[14:12] == 3'b010) begin
                known = 1'b1; use1 = 1'b1; use2 = 1'b1; uop = UOP_SW;
                op1 = rdata1 + imm_s; waddr = 5'd0;
            end
            OPC_JAL: begin
                known = 1'b1; uop = UOP_JAL; op1 = f_pc_i; op2 = imm_j;
            end
            OPC_JALR: if (f_inst_i[14:12] == 3'b000) begin
                known = 1'b1; use1 = 1'b1; uop = UOP_JALR; op2 = imm_i;
            end
            OPC_BRANCH: if (f_inst_i[14:12] == 3'b001) begin
                known = 1'b1; use1 = 1'b1; use2 = 1'b1; uop = UOP_BNE;
                waddr = 5'd0; pc_out = f_pc_i + imm_b;
            end
            default: ;
        endcase
    end

    // Legality, RAW hazard check and lowest-index ready pipe selection.
    always_comb begin
        vec     = uop_vec(uop);
        any_sup = '0;
        sel     = '0;
        found   = 1'b0;
        for (int k = 0; k < P_NUM_PIPES; k++) begin
            any_sup = any_sup | P_PIPE_SUBSETS[k];
            if (!found && |(P_PIPE_SUBSETS[k] & vec) && ex_rdy_i[k]) begin
                sel[k] = 1'b1;
                found  = 1'b1;
            end
        end
        legal = known && |(P_ISA_SUBSET & any_sup & vec);
        haz   = (use1 && rs1 != 5'd0 && pend_q[rs1] && !(cmp_wr && cmp_waddr_i == rs1)) ||
                (use2 && rs2 != 5'd0 && pend_q[rs2] && !(cmp_wr && cmp_waddr_i == rs2));
        issue   = !rst && f_val_i && legal && !haz && found;
        f_rdy_o = !rst && (!legal || (!haz && found));
    end

    // Broadcast the decoded micro-op; only the selected pipe sees val.
    always_comb begin
        for (int k = 0; k < P_NUM_PIPES; k++) begin
            ex_pc_o[k]      = pc_out;
            ex_op1_o[k]     = op1;
            ex_op2_o[k]     = op2;
            ex_waddr_o[k]   = waddr;
            ex_uop_o[k]     = uop;
            ex_seq_num_o[k] = seq_q;
        end
        ex_val_o = issue ? sel : '0;
    end

    // Scoreboard and sequence counter next state; a same-cycle issue re-marks
    // a register that is completing.
    always_comb begin
        pend_d = pend_q;
        if (cmp_wr && cmp_waddr_i != 5'd0) pend_d[cmp_waddr_i] = 1'b0;
        if (issue && waddr != 5'd0)        pend_d[waddr]       = 1'b1;
        seq_d = issue ? seq_q + P_SEQ_BITS'(1) : seq_q;
    end

    // Scoreboard and sequence counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            seq_q  <= '0;
        end else begin
            pend_q <= pend_d;
            seq_q  <= seq_d;
        end
    end

    // Illegal instructions are consumed without issue; flag them in simulation.
    always_ff @(posedge clk) begin
        if (!rst && f_val_i)
            assert (legal) else $error("decode_basic: illegal inst %h at pc %h dropped", f_inst_i, f_pc_i);
    end

endmodule

// File: tb/tb_decode_basic.sv
// Self-checking bench for decode_basic: directed scenarios plus a randomized
// run against a scoreboard-level reference model.
module tb_decode_basic;
    import decode_basic_pkg::*;

    localparam int NP = 2;
    localparam int SB = 3;
    localparam int K_ADD = 0, K_ADDI = 1, K_MUL = 2, K_LW = 3, K_SW = 4, K_JAL = 5, K_JALR = 6, K_BNE = 7;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] f_inst, f_pc;
    logic f_val, f_rdy;
    logic [NP-1:0][31:0] ex_pc, ex_op1, ex_op2;
    logic [NP-1:0][4:0] ex_waddr;
    rv_uop_e [NP-1:0] ex_uop;
    logic [NP-1:0][SB-1:0] ex_seq;
    logic [NP-1:0] ex_val, ex_rdy;
    logic cmp_val, cmp_wen;
    logic [SB-1:0] cmp_seq;
    logic [4:0] cmp_waddr;
    logic [31:0] cmp_wdata;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decode_basic #(
        .P_ISA_SUBSET   (P_TINYRV1),
        .P_NUM_PIPES    (NP),
        .P_PIPE_SUBSETS ({P_TINYRV1, OP_ADD_VEC}),
        .P_SEQ_BITS     (SB)
    ) dut (
        .clk(clk), .rst(rst),
        .f_inst_i(f_inst), .f_pc_i(f_pc), .f_val_i(f_val), .f_rdy_o(f_rdy),
        .ex_pc_o(ex_pc), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_waddr_o(ex_waddr),
        .ex_uop_o(ex_uop), .ex_seq_num_o(ex_seq), .ex_val_o(ex_val), .ex_rdy_i(ex_rdy),
        .cmp_val_i(cmp_val), .cmp_seq_num_i(cmp_seq), .cmp_waddr_i(cmp_waddr),
        .cmp_wdata_i(cmp_wdata), .cmp_wen_i(cmp_wen)
    );

    function automatic logic [31:0] enc(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input int imm);
        logic [31:0] iv;
        iv = imm;
        case (kind)
            K_ADD:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_MUL:   return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_ADDI:  return {iv[11:0], rs1, 3'b000, rd, 7'b0010011};
            K_LW:    return {iv[11:0], rs1, 3'b010, rd, 7'b0000011};
            K_SW:    return {iv[11:5], rs2, rs1, 3'b010, iv[4:0], 7'b0100011};
            K_JAL:   return {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'b1101111};
            K_JALR:  return {iv[11:0], rs1, 3'b000, rd, 7'b1100111};
            default: return {iv[12], iv[10:5], rs2, rs1, 3'b001, iv[4:1], iv[11], 7'b1100011};
        endcase
    endfunction

    task automatic drv(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic [1:0] rdy);
        f_val = v; f_inst = inst; f_pc = pc; ex_rdy = rdy;
    endtask

    task automatic pub(input logic v, input logic [4:0] a, input logic [31:0] d);
        cmp_val = v; cmp_wen = v; cmp_waddr = a; cmp_wdata = d; cmp_seq = 'x;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drv(1'b1, enc(K_ADD, 5'd1, 5'd2, 5'd3, 0), 32'h100, 2'b11);
        pub(1'b1, 5'd1, 32'h55);
        repeat (2) @(negedge clk);
        #1;
        total++; if (f_rdy !== 1'b0 || ex_val !== 2'b00) begin
            bad++; $display("FAIL reset_idle: rdy=%b val=%b want rdy=0 val=00", f_rdy, ex_val);
        end
        @(negedge clk);
        rst = 1'b0;
        pub(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_basic;
        drv(1'b1, enc(K_MUL, 5'd1, 5'd0, 5'd0, 0), 32'd0, 2'b11);
        #1;
        total++; if (f_rdy !== 1'b1 || ex_val !== 2'b10) begin
            bad++; $display("FAIL basic_mul_route: rdy=%b val=%b want 1 10", f_rdy, ex_val);
        end
        total++; if ({ex_pc[1], ex_op1[1], ex_op2[1], ex_waddr[1], ex_uop[1], ex_seq[1]} !==
                     {32'd0, 32'd0, 32'd0, 5'd1, UOP_MUL, 3'd0}) begin
            bad++; $display("FAIL basic_mul_uop: got %h want pc0 0 0 x1 MUL seq0",
                            {ex_pc[1], ex_op1[1], ex_op2[1], ex_waddr[1], ex_uop[1], ex_seq[1]});
        end
        step;
        drv(1'b1, enc(K_ADDI, 5'd1, 5'd0, 5'd0, 10), 32'd4, 2'b11);
        #1;
        total++; if (f_rdy !== 1'b1 || ex_val !== 2'b01) begin
            bad++; $display("FAIL basic_addi_waw: rdy=%b val=%b want 1 01", f_rdy, ex_val);
        end
        total++; if ({ex_pc[0], ex_op1[0], ex_op2[0], ex_waddr[0], ex_uop[0], ex_seq[0]} !==
                     {32'd4, 32'd0, 32'd10, 5'd1, UOP_ADD, 3'd1}) begin
            bad++; $display("FAIL basic_addi_uop: got %h want pc4 0 10 x1 ADD seq1",
                            {ex_pc[0], ex_op1[0], ex_op2[0], ex_waddr[0], ex_uop[0], ex_seq[0]});
        end
        step;
        drv(1'b0, 32'd0, 32'd0, 2'b11); pub(1'b1, 5'd1, 32'd10);
        step;
        pub(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_raw;
        pub(1'b1, 5'd1, 32'd3); step;
        pub(1'b1, 5'd2, 32'd7); step;
        pub(1'b0, 5'd0, 32'd0);
        drv(1'b1, enc(K_ADD, 5'd4, 5'd1, 5'd2, 0), 32'd8, 2'b11);
        #1;
        total++; if (ex_val !== 2'b01 || {ex_op1[0], ex_op2[0], ex_waddr[0], ex_uop[0], ex_seq[0]} !==
                     {32'd3, 32'd7, 5'd4, UOP_ADD, 3'd2}) begin
            bad++; $display("FAIL raw_first: val=%b got %h want 3 7 x4 ADD seq2", ex_val,
                            {ex_op1[0], ex_op2[0], ex_waddr[0], ex_uop[0], ex_seq[0]});
        end
        step;
        drv(1'b1, enc(K_ADD, 5'd2, 5'd5, 5'd4, 0), 32'd12, 2'b11);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (f_rdy !== 1'b0 || ex_val !== 2'b00) begin
                bad++; $display("FAIL raw_stall: cyc=%0d rdy=%b val=%b want 0 00", i, f_rdy, ex_val);
            end
            @(negedge clk);
        end
        pub(1'b1, 5'd4, 32'd10);
        #1;
        total++; if (ex_val !== 2'b01 || {ex_pc[0], ex_op1[0], ex_op2[0], ex_waddr[0], ex_seq[0]} !==
                     {32'd12, 32'd0, 32'd10, 5'd2, 3'd3}) begin
            bad++; $display("FAIL raw_bypass: val=%b got %h want pc12 0 10 x2 seq3", ex_val,
                            {ex_pc[0], ex_op1[0], ex_op2[0], ex_waddr[0], ex_seq[0]});
        end
        step;
        drv(1'b0, 32'd0, 32'd0, 2'b11); pub(1'b1, 5'd2, 32'd5);
        step;
        pub(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_imm;
        pub(1'b1, 5'd1, 32'd9); step;
        pub(1'b0, 5'd0, 32'd0);
        drv(1'b1, enc(K_ADDI, 5'd3, 5'd1, 5'd0, 10), 32'd16, 2'b11);
        #1;
        total++; if (ex_val !== 2'b01 || {ex_op1[0], ex_op2[0], ex_waddr[0], ex_seq[0]} !==
                     {32'd9, 32'd10, 5'd3, 3'd4}) begin
            bad++; $display("FAIL imm_small: val=%b got %h want 9 10 x3 seq4", ex_val,
                            {ex_op1[0], ex_op2[0], ex_waddr[0], ex_seq[0]});
        end
        step;
        drv(1'b0, 32'd0, 32'd0, 2'b11); pub(1'b1, 5'd3, 32'd13); step;
        pub(1'b0, 5'd0, 32'd0);
        drv(1'b1, enc(K_ADDI, 5'd2, 5'd3, 5'd0, 2047), 32'd20, 2'b11);
        #1;
        total++; if (ex_val !== 2'b01 || {ex_op1[0], ex_op2[0], ex_waddr[0], ex_seq[0]} !==
                     {32'd13, 32'd2047, 5'd2, 3'd5}) begin
            bad++; $display("FAIL imm_max: val=%b got %h want 13 2047 x2 seq5", ex_val,
                            {ex_op1[0], ex_op2[0], ex_waddr[0], ex_seq[0]});
        end
        step;
        drv(1'b1, enc(K_ADDI, 5'd6, 5'd0, 5'd0, -2048), 32'd24, 2'b11);
        #1;
        total++; if (ex_val !== 2'b01 || {ex_op2[0], ex_waddr[0], ex_seq[0]} !== {32'hFFFF_F800, 5'd6, 3'd6}) begin
            bad++; $display("FAIL imm_min: val=%b got %h want fffff800 x6 seq6", ex_val,
                            {ex_op2[0], ex_waddr[0], ex_seq[0]});
        end
        step;
        drv(1'b0, 32'd0, 32'd0, 2'b11); pub(1'b1, 5'd2, 32'd1); step;
        pub(1'b1, 5'd6, 32'd2); step;
        pub(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_routing;
        drv(1'b1, enc(K_ADD, 5'd7, 5'd0, 5'd0, 0), 32'd28, 2'b10);
        #1;
        total++; if (ex_val !== 2'b10 || ex_seq[1] !== 3'd7) begin
            bad++; $display("FAIL route_add_fallback: val=%b seq=%0d want 10 seq7", ex_val, ex_seq[1]);
        end
        step;
        drv(1'b1, enc(K_MUL, 5'd8, 5'd0, 5'd0, 0), 32'd32, 2'b01);
        #1;
        total++; if (f_rdy !== 1'b0 || ex_val !== 2'b00) begin
            bad++; $display("FAIL route_mul_blocked: rdy=%b val=%b want 0 00", f_rdy, ex_val);
        end
        step;
        drv(1'b1, enc(K_ADD, 5'd9, 5'd0, 5'd0, 0), 32'd36, 2'b00);
        #1;
        total++; if (f_rdy !== 1'b0 || ex_val !== 2'b00) begin
            bad++; $display("FAIL route_none_ready: rdy=%b val=%b want 0 00", f_rdy, ex_val);
        end
        step;
        ex_rdy = 2'b11;
        #1;
        total++; if (ex_val !== 2'b01 || ex_seq[0] !== 3'd0) begin
            bad++; $display("FAIL route_seq_wrap: val=%b seq=%0d want 01 seq0", ex_val, ex_seq[0]);
        end
        step;
        drv(1'b1, enc(K_BNE, 5'd0, 5'd0, 5'd0, -8), 32'h40, 2'b11);
        #1;
        total++; if (ex_val !== 2'b10 || {ex_pc[1], ex_waddr[1], ex_uop[1], ex_seq[1]} !==
                     {32'h38, 5'd0, UOP_BNE, 3'd1}) begin
            bad++; $display("FAIL route_bne_target: val=%b got %h want 38 x0 BNE seq1", ex_val,
                            {ex_pc[1], ex_waddr[1], ex_uop[1], ex_seq[1]});
        end
        step;
        drv(1'b0, 32'd0, 32'd0, 2'b11); pub(1'b1, 5'd7, 32'd0); step;
        pub(1'b1, 5'd9, 32'd0); step;
        pub(1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_midreset;
        drv(1'b1, enc(K_ADD, 5'd10, 5'd3, 5'd0, 0), 32'h50, 2'b11);
        #1;
        total++; if (ex_val !== 2'b01 || ex_op1[0] !== 32'd13) begin
            bad++; $display("FAIL midrst_pre: val=%b op1=%0d want 01 13", ex_val, ex_op1[0]);
        end
        step;
        rst = 1'b1;
        #1;
        total++; if (f_rdy !== 1'b0 || ex_val !== 2'b00) begin
            bad++; $display("FAIL midrst_hold: rdy=%b val=%b want 0 00", f_rdy, ex_val);
        end
        step;
        rst = 1'b0;
        drv(1'b1, enc(K_ADD, 5'd11, 5'd3, 5'd10, 0), 32'h54, 2'b11);
        #1;
        total++; if (ex_val !== 2'b01 || {ex_op1[0], ex_op2[0], ex_seq[0]} !== {32'd0, 32'd0, 3'd0}) begin
            bad++; $display("FAIL midrst_cleared: val=%b got %h want 0 0 seq0", ex_val,
                            {ex_op1[0], ex_op2[0], ex_seq[0]});
        end
        step;
        drv(1'b0, 32'd0, 32'd0, 2'b11);
    endtask

    task automatic test_random;
        logic [31:0] R [32];
        logic        pend [32];
        int seq, kind, imm, pipe, pl[$];
        logic [4:0] rd, rs1, rs2, ewa;
        logic [31:0] pc, v1, v2, eop1, eop2, epc;
        logic have, u1, u2, haz, fire, cw;
        rv_uop_e eu;
        rst = 1'b1; drv(1'b0, 32'd0, 32'd0, 2'b00); pub(1'b0, 5'd0, 32'd0);
        step;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin R[i] = '0; pend[i] = 1'b0; end
        seq = 0; have = 1'b0; kind = 0; imm = 0; rd = '0; rs1 = '0; rs2 = '0; pc = '0;
        for (int c = 0; c < 600; c++) begin
            if (!have && $urandom_range(0, 9) < 7) begin
                have = 1'b1;
                kind = int'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
                pc = $urandom & 32'hFFFF_FFFC;
                case (kind)
                    K_BNE:   imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                    K_JAL:   imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                    K_ADD, K_MUL: imm = 0;
                    default: imm = int'($urandom_range(0, 4095)) - 2048;
                endcase
            end
            drv(have, have ? enc(kind, rd, rs1, rs2, imm) : 32'd0, pc,
                {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6)});
            pl.delete();
            for (int r = 1; r < 32; r++) if (pend[r]) pl.push_back(r);
            pub(1'b0, 5'd0, 32'd0);
            if (pl.size() > 0 && $urandom_range(0, 1) == 1)
                pub(1'b1, 5'(pl[$urandom_range(0, pl.size() - 1)]), $urandom);
            else if ($urandom_range(0, 5) == 0) begin
                pub(1'b1, 5'($urandom_range(0, 7)), $urandom);
                if ($urandom_range(0, 1) == 1) cmp_wen = 1'b0; else cmp_waddr = 5'd0;
            end
            #1;
            cw = cmp_val && cmp_wen;
            v1 = (rs1 == 0) ? 32'd0 : (cw && cmp_waddr == rs1) ? cmp_wdata : R[rs1];
            v2 = (rs2 == 0) ? 32'd0 : (cw && cmp_waddr == rs2) ? cmp_wdata : R[rs2];
            u1 = (kind != K_JAL);
            u2 = (kind == K_ADD || kind == K_MUL || kind == K_SW || kind == K_BNE);
            haz = (u1 && rs1 != 0 && pend[rs1] && !(cw && cmp_waddr == rs1)) ||
                  (u2 && rs2 != 0 && pend[rs2] && !(cw && cmp_waddr == rs2));
            epc = pc; eop1 = v1; eop2 = u2 ? v2 : 32'(imm); ewa = rd;
            case (kind)
                K_ADD, K_ADDI: eu = UOP_ADD;
                K_MUL:  eu = UOP_MUL;
                K_LW:   eu = UOP_LW;
                K_SW:   begin eu = UOP_SW; eop1 = v1 + 32'(imm); ewa = 5'd0; end
                K_JAL:  begin eu = UOP_JAL; eop1 = pc; end
                K_JALR: eu = UOP_JALR;
                default: begin eu = UOP_BNE; ewa = 5'd0; epc = pc + 32'(imm); end
            endcase
            pipe = -1;
            if (ex_rdy[0] && eu == UOP_ADD) pipe = 0;
            else if (ex_rdy[1]) pipe = 1;
            fire = have && !haz && pipe >= 0;
            if (have) begin
                total++; if (f_rdy !== (!haz && pipe >= 0)) begin
                    bad++; $display("FAIL rand_rdy: cyc=%0d rdy=%b want %b", c, f_rdy, !haz && pipe >= 0);
                end
            end
            total++; if (ex_val !== (fire ? 2'(2'b01 << pipe) : 2'b00)) begin
                bad++; $display("FAIL rand_val: cyc=%0d val=%b want %b", c, ex_val, fire ? 2'(2'b01 << pipe) : 2'b00);
            end
            if (fire) begin
                total++; if ({ex_pc[pipe], ex_op1[pipe], ex_op2[pipe], ex_waddr[pipe], ex_uop[pipe], ex_seq[pipe]} !==
                             {epc, eop1, eop2, ewa, eu, SB'(seq)}) begin
                    bad++; $display("FAIL rand_uop: cyc=%0d got %h want %h", c,
                        {ex_pc[pipe], ex_op1[pipe], ex_op2[pipe], ex_waddr[pipe], ex_uop[pipe], ex_seq[pipe]},
                        {epc, eop1, eop2, ewa, eu, SB'(seq)});
                end
            end
            if (cw && cmp_waddr != 0) begin R[cmp_waddr] = cmp_wdata; pend[cmp_waddr] = 1'b0; end
            if (fire) begin
                if (ewa != 0) pend[ewa] = 1'b1;
                seq = (seq + 1) % (1 << SB);
                have = 1'b0;
            end
            step;
        end
        drv(1'b0, 32'd0, 32'd0, 2'b00); pub(1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b0, 32'd0, 32'd0, 2'b00);
        pub(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        test_reset;
        test_basic;
        test_raw;
        test_imm;
        test_routing;
        test_midreset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
